// File: rtl/bp_update_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_ctrl_if
//  Brief    : Resolution, prediction and predictor-update signal bundle for
//             the branch-predictor update controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface bp_update_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int GHR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Execute-stage resolution
    logic              res_valid_i;
    logic              res_ready_o;
    logic [PC_W-1:0]   res_pc_i;
    logic              res_taken_i;
    logic              res_mispredict_i;
    logic [GHR_W-1:0]  res_ghr_i;

    // Fetch-stage prediction
    logic              pred_valid_i;
    logic              pred_taken_i;

    // Predictor table update port
    logic              upd_stall_i;
    logic              upd_en_o;
    logic [PC_W-1:0]   upd_pc_o;
    logic              upd_taken_o;
    logic [GHR_W-1:0]  upd_ghr_o;

    // History and occupancy
    logic [GHR_W-1:0]  spec_ghr_o;
    logic [GHR_W-1:0]  commit_ghr_o;
    logic [CNT_W-1:0]  count_o;

    // Controller side
    modport slave (
        input  res_valid_i, res_pc_i, res_taken_i, res_mispredict_i, res_ghr_i,
        input  pred_valid_i, pred_taken_i, upd_stall_i,
        output res_ready_o, upd_en_o, upd_pc_o, upd_taken_o, upd_ghr_o,
        output spec_ghr_o, commit_ghr_o, count_o
    );

    // Pipeline / predictor side
    modport master (
        output res_valid_i, res_pc_i, res_taken_i, res_mispredict_i, res_ghr_i,
        output pred_valid_i, pred_taken_i, upd_stall_i,
        input  res_ready_o, upd_en_o, upd_pc_o, upd_taken_o, upd_ghr_o,
        input  spec_ghr_o, commit_ghr_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_ctrl
//  Brief    : Buffers resolved branches in an in-order FIFO, drains one per
//             cycle into the predictor tables, and maintains speculative and
//             committed global history registers.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int GHR_W = 8
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    bp_update_ctrl_if.slave   bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] commit_ghr;

    logic ready;
    logic push;
    logic pop;

    // Ready comes only from the occupancy register, so a pop cannot open a
    // slot in the same cycle and there is no path from stall or valid.
    assign ready = (count < FULL_CNT);
    assign push  = bus.res_valid_i & ready;
    assign pop   = (count != '0) & ~bus.upd_stall_i;

    assign bus.res_ready_o  = ready;
    assign bus.upd_en_o     = pop;
    assign bus.upd_pc_o     = pc_mem[rd_ptr];
    assign bus.upd_taken_o  = taken_mem[rd_ptr];
    assign bus.upd_ghr_o    = commit_ghr;
    assign bus.spec_ghr_o   = spec_ghr;
    assign bus.commit_ghr_o = commit_ghr;
    assign bus.count_o      = count;

    // FIFO storage: write the resolved branch at the write pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i] <= '0;
            end
            taken_mem <= '0;
        end else if (push) begin
            pc_mem[wr_ptr]    <= bus.res_pc_i;
            taken_mem[wr_ptr] <= bus.res_taken_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Committed history shifts in the direction of each branch as it retires
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            commit_ghr <= '0;
        end else if (pop) begin
            commit_ghr <= {commit_ghr[GHR_W-2:0], taken_mem[rd_ptr]};
        end
    end

    // Speculative history: an accepted mispredict rebuilds from the branch's
    // snapshot and overrides any same-cycle (wrong-path) fetch prediction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_ghr <= '0;
        end else if (push && bus.res_mispredict_i) begin
            spec_ghr <= {bus.res_ghr_i[GHR_W-2:0], bus.res_taken_i};
        end else if (bus.pred_valid_i) begin
            spec_ghr <= {spec_ghr[GHR_W-2:0], bus.pred_taken_i};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_update_ctrl
//  Brief    : Self-checking bench for bp_update_ctrl with a queue scoreboard
//             and reference history model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_update_ctrl;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int GHR_W = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    bp_update_ctrl_if #(.DEPTH(DEPTH), .PC_W(PC_W), .GHR_W(GHR_W)) bus ();

    bp_update_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .GHR_W(GHR_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Clock generation
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [PC_W:0]    sb_q [$];   // {pc, taken}
    logic [GHR_W-1:0] m_commit = '0;
    logic [GHR_W-1:0] m_spec   = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle on stable signals
    always @(negedge clk_i) begin
        logic [PC_W:0] e;
        logic          acc;
        logic          pop;
        if (rst_i) begin
            sb_q.delete();
            m_commit = '0;
            m_spec   = '0;
            check("rst_upd_en", 64'(bus.upd_en_o), 64'(0));
            check("rst_count",  64'(bus.count_o),  64'(0));
            check("rst_ready",  64'(bus.res_ready_o), 64'(1));
        end else begin
            check("count",      64'(bus.count_o),      64'(sb_q.size()));
            check("ready",      64'(bus.res_ready_o),  64'(sb_q.size() < DEPTH));
            check("spec_ghr",   64'(bus.spec_ghr_o),   64'(m_spec));
            check("commit_ghr", 64'(bus.commit_ghr_o), 64'(m_commit));
            acc = bus.res_valid_i && (sb_q.size() < DEPTH);
            pop = (sb_q.size() != 0) && !bus.upd_stall_i;
            check("upd_en", 64'(bus.upd_en_o), 64'(pop));
            if (pop) begin
                e = sb_q.pop_front();
                check("upd_pc",    64'(bus.upd_pc_o),    64'(e[PC_W:1]));
                check("upd_taken", 64'(bus.upd_taken_o), 64'(e[0]));
                check("upd_ghr",   64'(bus.upd_ghr_o),   64'(m_commit));
                m_commit = {m_commit[GHR_W-2:0], e[0]};
            end
            if (acc) begin
                sb_q.push_back({bus.res_pc_i, bus.res_taken_i});
            end
            if (acc && bus.res_mispredict_i) begin
                m_spec = {bus.res_ghr_i[GHR_W-2:0], bus.res_taken_i};
            end else if (bus.pred_valid_i) begin
                m_spec = {m_spec[GHR_W-2:0], bus.pred_taken_i};
            end
        end
    end

    // Apply one cycle of stimulus, return just after the clock edge
    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic t,
                        input logic m, input logic [GHR_W-1:0] g,
                        input logic pv, input logic pt, input logic st);
        bus.res_valid_i      = v;
        bus.res_pc_i         = pc;
        bus.res_taken_i      = t;
        bus.res_mispredict_i = m;
        bus.res_ghr_i        = g;
        bus.pred_valid_i     = pv;
        bus.pred_taken_i     = pt;
        bus.upd_stall_i      = st;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic st);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, st);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst_i = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        logic rdy;

        idle(1'b0);
        do_reset();
        check("reset_spec",   64'(bus.spec_ghr_o),   64'(0));
        check("reset_commit", 64'(bus.commit_ghr_o), 64'(0));
        check("reset_pc",     64'(bus.upd_pc_o),     64'(0));

        // Single push, 1-cycle latency
        step(1'b1, 32'h100, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t1_upd_en",  64'(bus.upd_en_o),    64'(1));
        check("t1_upd_pc",  64'(bus.upd_pc_o),    64'h100);
        check("t1_taken",   64'(bus.upd_taken_o), 64'(1));
        check("t1_upd_ghr", 64'(bus.upd_ghr_o),   64'h00);
        idle(1'b0);
        check("t1_commit",  64'(bus.commit_ghr_o), 64'h01);
        check("t1_count",   64'(bus.count_o),      64'(0));

        // Fill under stall, fifth offer refused, then drain in order
        do_reset();
        step(1'b1, 32'h10, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h20, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h30, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t2_count_full", 64'(bus.count_o),     64'(4));
        check("t2_ready_full", 64'(bus.res_ready_o), 64'(0));
        step(1'b1, 32'h50, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t2_fifth_refused", 64'(bus.count_o), 64'(4));
        check("t2_head", 64'(bus.upd_pc_o), 64'h10);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check("t2_commit", 64'(bus.commit_ghr_o), 64'h0B);
        check("t2_empty",  64'(bus.count_o),      64'(0));

        // Stream 16 entries through a full FIFO across pointer wrap
        do_reset();
        pushed = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h1000 + 32'(pushed * 4), pushed[0], 1'b0, '0, 1'b0, 1'b0, 1'b1);
            pushed++;
        end
        while (pushed < 16) begin
            rdy = bus.res_ready_o;
            step(1'b1, 32'h1000 + 32'(pushed * 4), pushed[0], 1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (rdy) pushed++;
            check("t3_count_min", 64'(bus.count_o >= 3'(DEPTH - 1)), 64'(1));
        end
        for (int i = 0; i < 6; i++) idle(1'b0);
        check("t3_drained", 64'(bus.count_o), 64'(0));

        // Speculative history and mispredict recovery
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("t4_spec", 64'(bus.spec_ghr_o), 64'h06);
        step(1'b1, 32'h200, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
        check("t4_mispredict", 64'(bus.spec_ghr_o), 64'h0B);
        idle(1'b0);

        // Push and pop together at count 1
        do_reset();
        step(1'b1, 32'hA0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("t5_count1", 64'(bus.count_o), 64'(1));
        step(1'b1, 32'hB0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("t5_count_hold", 64'(bus.count_o),     64'(1));
        check("t5_new_head",   64'(bus.upd_pc_o),    64'hB0);
        check("t5_new_taken",  64'(bus.upd_taken_o), 64'(1));
        idle(1'b0);

        // Reset mid-drain discards remaining entries
        do_reset();
        step(1'b1, 32'hC0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'hC4, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hC8, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hCC, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("t6_count3", 64'(bus.count_o), 64'(3));
        rst_i = 1'b1;
        #1;
        check("t6_rst_upd_en", 64'(bus.upd_en_o),     64'(0));
        check("t6_rst_count",  64'(bus.count_o),      64'(0));
        check("t6_rst_ready",  64'(bus.res_ready_o),  64'(1));
        check("t6_rst_pc",     64'(bus.upd_pc_o),     64'(0));
        check("t6_rst_taken",  64'(bus.upd_taken_o),  64'(0));
        check("t6_rst_ughr",   64'(bus.upd_ghr_o),    64'(0));
        check("t6_rst_spec",   64'(bus.spec_ghr_o),   64'(0));
        check("t6_rst_commit", 64'(bus.commit_ghr_o), 64'(0));
        idle(1'b0);
        idle(1'b0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            check("t6_no_update", 64'(bus.upd_en_o), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
